// File: rtl/dot_product_engine.sv
// Dot-product engine: streams Length word pairs from two 1-cycle-latency SRAMs,
// sums the per-lane unsigned products, then writes the total to a result SRAM.
module dot_product_engine #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Addr_Width = 4,
  parameter int unsigned Para_Deg   = 4,
  parameter int unsigned Acc_Width  = Para_Deg * Data_Width
) (
  input  logic                           clk,
  input  logic                           Rst_n,
  input  logic                           Start,
  input  logic [Addr_Width:0]            Length,
  input  logic [Addr_Width-1:0]          Base_A,
  input  logic [Addr_Width-1:0]          Base_B,
  input  logic [Addr_Width-1:0]          Out_Addr,
  output logic                           A_Chip_Select,
  output logic                           A_En_Read,
  output logic [Addr_Width-1:0]          A_Read_Addr,
  input  logic [Para_Deg*Data_Width-1:0] A_Read_Data,
  output logic                           B_Chip_Select,
  output logic                           B_En_Read,
  output logic [Addr_Width-1:0]          B_Read_Addr,
  input  logic [Para_Deg*Data_Width-1:0] B_Read_Data,
  output logic                           C_Chip_Select,
  output logic                           C_En_Write,
  output logic [Addr_Width-1:0]          C_Write_Addr,
  output logic [Para_Deg*Data_Width-1:0] C_Write_Data,
  output logic                           Busy,
  output logic                           Done,
  output logic [Acc_Width-1:0]           Result
);

  localparam int unsigned WordW = Para_Deg * Data_Width;
  localparam int unsigned ProdW = 2 * Data_Width;

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [Addr_Width:0]   r_len, r_cnt, w_cnt_inc;
  logic [Addr_Width-1:0] r_base_a, r_base_b, r_out_addr;
  logic                  r_rd_vld;
  logic [Acc_Width-1:0]  r_acc, r_result, w_dot;
  logic [ProdW-1:0]      w_prod [Para_Deg];
  logic [WordW-1:0]      w_acc_word;
  logic                  w_rd_issue, w_start;

  assign w_start   = (r_state == StIdle) && Start;
  assign w_cnt_inc = r_cnt + (Addr_Width+1)'(1);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d     = r_state;
    w_rd_issue    = 1'b0;
    A_Chip_Select = 1'b0;
    A_En_Read     = 1'b0;
    A_Read_Addr   = '0;
    B_Chip_Select = 1'b0;
    B_En_Read     = 1'b0;
    B_Read_Addr   = '0;
    C_Chip_Select = 1'b0;
    C_En_Write    = 1'b0;
    C_Write_Addr  = '0;
    C_Write_Data  = '0;
    Done          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (Start) w_state_d = (Length != '0) ? StRead : StWrite;
      end
      StRead: begin
        w_rd_issue    = 1'b1;
        A_Chip_Select = 1'b1;
        A_En_Read     = 1'b1;
        B_Chip_Select = 1'b1;
        B_En_Read     = 1'b1;
        // Address arithmetic is Addr_Width wide, so it wraps around the SRAM.
        A_Read_Addr   = r_base_a + r_cnt[Addr_Width-1:0];
        B_Read_Addr   = r_base_b + r_cnt[Addr_Width-1:0];
        if (w_cnt_inc == r_len) w_state_d = StDrain;
      end
      StDrain: w_state_d = StWrite;
      StWrite: begin
        C_Chip_Select = 1'b1;
        C_En_Write    = 1'b1;
        C_Write_Addr  = r_out_addr;
        C_Write_Data  = w_acc_word;
        w_state_d     = StDone;
      end
      StDone: begin
        Done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_dot = '0;
    for (int i = 0; i < int'(Para_Deg); i++) begin
      w_prod[i] = ProdW'(A_Read_Data[i*Data_Width +: Data_Width])
                * ProdW'(B_Read_Data[i*Data_Width +: Data_Width]);
      w_dot     = w_dot + Acc_Width'(w_prod[i]);
    end
  end

  generate
    if (Acc_Width >= WordW) begin : g_trunc
      assign w_acc_word = r_acc[WordW-1:0];
    end else begin : g_zext
      assign w_acc_word = {{(WordW-Acc_Width){1'b0}}, r_acc};
    end
  endgenerate

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_len      <= '0;
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_out_addr <= '0;
      r_cnt      <= '0;
      r_rd_vld   <= 1'b0;
      r_acc      <= '0;
      r_result   <= '0;
    end else if (w_start) begin
      r_len      <= Length;
      r_base_a   <= Base_A;
      r_base_b   <= Base_B;
      r_out_addr <= Out_Addr;
      r_cnt      <= '0;
      r_rd_vld   <= 1'b0;
      r_acc      <= '0;
    end else begin
      // Read data arrives the cycle after the issue, so accumulation lags one cycle.
      r_rd_vld <= w_rd_issue;
      if (w_rd_issue)            r_cnt    <= w_cnt_inc;
      if (r_rd_vld)              r_acc    <= r_acc + w_dot;
      if (r_state == StWrite)    r_result <= r_acc;
    end
  end

  assign Busy   = (r_state != StIdle);
  assign Result = r_result;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench: driver queues expected reads/writes/done events from a plain
// arithmetic model; a negedge monitor pops and compares whatever the DUT presents.
module tb_dot_product_engine;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PD = 4;
  localparam int ACC = 32;
  localparam int WW = PD * DW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic [AW:0]   Length = '0;
  logic [AW-1:0] Base_A = '0, Base_B = '0, Out_Addr = '0;
  logic          A_Chip_Select, A_En_Read, B_Chip_Select, B_En_Read;
  logic [AW-1:0] A_Read_Addr, B_Read_Addr, C_Write_Addr;
  logic [WW-1:0] A_Read_Data, B_Read_Data, C_Write_Data;
  logic          C_Chip_Select, C_En_Write, Busy, Done;
  logic [ACC-1:0] Result;

  logic [WW-1:0] mem_a [DEPTH];
  logic [WW-1:0] mem_b [DEPTH];

  typedef struct {int cyc; logic [AW-1:0] a; logic [AW-1:0] b;} rd_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [ACC-1:0] data;} wr_t;
  rd_t rq[$];
  wr_t wq[$];
  wr_t dq[$];
  rd_t m_rd;
  wr_t m_wr;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  dot_product_engine #(
    .Data_Width(DW), .Addr_Width(AW), .Para_Deg(PD), .Acc_Width(ACC)
  ) dut (
    .clk(clk), .Rst_n(Rst_n), .Start(Start), .Length(Length),
    .Base_A(Base_A), .Base_B(Base_B), .Out_Addr(Out_Addr),
    .A_Chip_Select(A_Chip_Select), .A_En_Read(A_En_Read),
    .A_Read_Addr(A_Read_Addr), .A_Read_Data(A_Read_Data),
    .B_Chip_Select(B_Chip_Select), .B_En_Read(B_En_Read),
    .B_Read_Addr(B_Read_Addr), .B_Read_Data(B_Read_Data),
    .C_Chip_Select(C_Chip_Select), .C_En_Write(C_En_Write),
    .C_Write_Addr(C_Write_Addr), .C_Write_Data(C_Write_Data),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand SRAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (A_Chip_Select && A_En_Read) A_Read_Data <= mem_a[A_Read_Addr];
    if (B_Chip_Select && B_En_Read) B_Read_Data <= mem_b[B_Read_Addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [ACC-1:0] ref_dot(input int n, input int ba, input int bb);
    longint s = 0;
    logic [WW-1:0] wa, wb;
    for (int k = 0; k < n; k++) begin
      wa = mem_a[(ba + k) % DEPTH];
      wb = mem_b[(bb + k) % DEPTH];
      for (int l = 0; l < PD; l++) s += longint'(wa[l*DW +: DW]) * longint'(wb[l*DW +: DW]);
    end
    return ACC'(s);
  endfunction

  always @(negedge clk) begin
    if (Rst_n) begin
      if (A_En_Read || B_En_Read || A_Chip_Select || B_Chip_Select) begin
        if (rq.size() == 0) chk("rd_unexpected", {A_En_Read, B_En_Read}, 2'b00);
        else begin
          m_rd = rq.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(m_rd.cyc));
          chk("rd_ctrl", {A_Chip_Select, A_En_Read, B_Chip_Select, B_En_Read}, 4'hf);
          chk("rd_addr_a", A_Read_Addr, m_rd.a);
          chk("rd_addr_b", B_Read_Addr, m_rd.b);
        end
      end
      if (C_En_Write || C_Chip_Select) begin
        if (wq.size() == 0) chk("wr_unexpected", {C_Chip_Select, C_En_Write}, 2'b00);
        else begin
          m_wr = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(m_wr.cyc));
          chk("wr_ctrl", {C_Chip_Select, C_En_Write}, 2'b11);
          chk("wr_addr", C_Write_Addr, m_wr.addr);
          chk("wr_data", C_Write_Data, m_wr.data);
        end
      end else if (C_Write_Data !== '0) chk("wr_data_idle", C_Write_Data, 0);
      if (Done) begin
        if (dq.size() == 0) chk("done_unexpected", Done, 0);
        else begin
          m_wr = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(m_wr.cyc));
          chk("done_result", Result, m_wr.data);
          chk("done_busy", Busy, 1);
        end
      end
    end
  end

  task automatic wait_idle();
    int b = 0;
    while (Busy && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: Busy still 1 after %0d cycles", b);
    end
  endtask

  // exp_ovr >= 0 supplies a hand-derived expected result instead of the model.
  task automatic run_job(input int n, input int ba, input int bb, input int oa,
                         input longint exp_ovr, input bit poke);
    int t0;
    logic [ACC-1:0] e;
    wait_idle();
    Length = (AW+1)'(n); Base_A = AW'(ba); Base_B = AW'(bb); Out_Addr = AW'(oa);
    Start = 1'b1;
    t0 = cyc;
    e = (exp_ovr >= 0) ? ACC'(exp_ovr) : ref_dot(n, ba, bb);
    for (int k = 0; k < n; k++) rq.push_back('{t0 + 1 + k, AW'((ba + k) % DEPTH), AW'((bb + k) % DEPTH)});
    wq.push_back('{(n > 0) ? t0 + n + 2 : t0 + 1, AW'(oa), e});
    dq.push_back('{(n > 0) ? t0 + n + 3 : t0 + 2, AW'(oa), e});
    @(posedge clk); #1;
    Start = 1'b0;
    // Scramble job inputs mid-job; the latched copies must be used.
    Length = (AW+1)'($urandom_range(0, DEPTH));
    Base_A = AW'($urandom); Base_B = AW'($urandom); Out_Addr = AW'($urandom);
    if (poke) begin
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
    end
  endtask

  task automatic fill_mem(input logic [WW-1:0] va, input logic [WW-1:0] vb, input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = rnd ? WW'($urandom) : va;
      mem_b[i] = rnd ? WW'($urandom) : vb;
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_mem('0, '0, 1'b1);
    Start = 1'b1; Length = 5'd9; Base_A = 4'd7; Base_B = 4'd2; Out_Addr = 4'd1;
    #12;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_rd_ctrl", {A_Chip_Select, A_En_Read, B_Chip_Select, B_En_Read}, 0);
    chk("rst_rd_addr", {A_Read_Addr, B_Read_Addr}, 0);
    chk("rst_wr", {C_Chip_Select, C_En_Write, C_Write_Addr, C_Write_Data}, 0);
    Start = 1'b0;
    @(posedge clk); #1;
    Rst_n = 1'b1;
    @(posedge clk); #1;

    fill_mem(32'h0101_0101, 32'h0202_0202, 1'b0);
    run_job(4, 0, 0, 10, 32, 1'b0);
    run_job(0, 9, 4, 5, 0, 1'b0);
    wait_idle();
    fill_mem('0, '0, 1'b1);
    run_job(4, 14, 3, 7, -1, 1'b0);
    wait_idle();
    fill_mem(32'hffff_ffff, 32'hffff_ffff, 1'b0);
    run_job(16, 5, 11, 3, 4161600, 1'b0);
    wait_idle();
    chk("result_held", Result, 32'h003f_8040);

    fill_mem('0, '0, 1'b1);
    for (int j = 0; j < 14; j++)
      run_job($urandom_range(0, DEPTH), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), -1, 1'($urandom));

    // Abandon a job with reset in its second cycle.
    wait_idle();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = WW'($urandom) | 1;
      mem_b[i] = WW'($urandom) | 1;
    end
    run_job(3, 2, 6, 8, -1, 1'b0);
    wait_idle();
    Length = 5'd4; Base_A = 4'd1; Base_B = 4'd9; Out_Addr = 4'd12;
    Start = 1'b1;
    for (int k = 0; k < 4; k++) rq.push_back('{cyc + 1 + k, AW'(1 + k), AW'(9 + k)});
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;
    Rst_n = 1'b0;
    rq.delete();
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_result", Result, 0);
    chk("abort_outputs", {A_Chip_Select, A_En_Read, B_Chip_Select, B_En_Read,
                          C_Chip_Select, C_En_Write, C_Write_Data, Done}, 0);
    repeat (2) @(posedge clk);
    #1;
    Rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle", Busy, 0);
    run_job(5, 12, 13, 2, -1, 1'b1);

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("rq_left", 64'(rq.size()), 0);
    chk("wq_left", 64'(wq.size()), 0);
    chk("dq_left", 64'(dq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
